// File: rtl/spi_master_ctrl_if.sv
// Word handshake, configuration and SPI pin bundle for spi_master_ctrl.
// master = the controller itself, slave = the host/pin environment around it.
interface spi_master_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  cpol;
  logic                  cpha;
  logic [1:0]            lanes;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  busy;
  logic                  sclk;
  logic                  cs;
  logic [3:0]            mosi;
  logic [3:0]            miso;

  modport master (
    input  tx_data, tx_valid, cpol, cpha, lanes, miso,
    output tx_ready, rx_data, rx_valid, busy, sclk, cs, mosi
  );

  modport slave (
    output tx_data, tx_valid, cpol, cpha, lanes, miso,
    input  tx_ready, rx_data, rx_valid, busy, sclk, cs, mosi
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master: serialises one parallel word per transfer over 1, 2 or 4 lanes
// in any CPOL/CPHA mode and returns the word captured on miso.
module spi_master_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2,
  parameter int CS_SETUP   = 1,
  parameter int CS_HOLD    = 1
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_ctrl_if.master bus
);
  localparam int CNT_MAX = (CLK_DIV > CS_SETUP) ? ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD)
                                                : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int EDGE_W  = $clog2(2 * DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t                state, state_next;
  logic [CNT_W-1:0]      cnt;
  logic [EDGE_W-1:0]     edge_cnt, edge_last;
  logic                  first_idle;
  logic                  cpol_q, cpha_q;
  logic [1:0]            lmode_q, lmode_in;
  logic [DATA_WIDTH-1:0] tx_sr, rx_sr;
  logic                  accept, tick, last_edge, leading, drive_beat, sample_beat;

  // Lane mode encoding: 0 = single, 1 = dual, 2 = quad.
  function automatic logic [3:0] beat_out(input logic [DATA_WIDTH-1:0] sr, input logic [1:0] lm);
    logic [3:0] b;
    b = 4'b0000;
    case (lm)
      2'd1:    b[1:0] = sr[DATA_WIDTH-1 -: 2];
      2'd2:    b      = sr[DATA_WIDTH-1 -: 4];
      default: b[0]   = sr[DATA_WIDTH-1];
    endcase
    return b;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] sr, input logic [1:0] lm);
    case (lm)
      2'd1:    return sr << 2;
      2'd2:    return sr << 4;
      default: return sr << 1;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] sr, input logic [3:0] m,
                                                     input logic [1:0] lm);
    case (lm)
      2'd1:    return (sr << 2) | DATA_WIDTH'(m[1:0]);
      2'd2:    return (sr << 4) | DATA_WIDTH'(m);
      default: return (sr << 1) | DATA_WIDTH'(m[0]);
    endcase
  endfunction

  assign lmode_in     = (bus.lanes == 2'd3) ? 2'd0 : bus.lanes;
  assign bus.tx_ready = (state == IDLE) && !first_idle;
  assign accept       = bus.tx_ready && bus.tx_valid;
  assign tick         = (state == SHIFT) && (cnt == CNT_W'(CLK_DIV - 1));
  assign last_edge    = tick && (edge_cnt == edge_last);
  assign leading      = ~edge_cnt[0];
  assign drive_beat   = tick && !last_edge && (cpha_q ? leading : !leading);
  assign sample_beat  = tick && (cpha_q ? !leading : leading);

  always_comb begin
    edge_last = EDGE_W'(2 * DATA_WIDTH - 1);
    case (lmode_q)
      2'd1:    edge_last = EDGE_W'(DATA_WIDTH - 1);
      2'd2:    edge_last = EDGE_W'(DATA_WIDTH / 2 - 1);
      default: edge_last = EDGE_W'(2 * DATA_WIDTH - 1);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SETUP;
      SETUP:   if (cnt == CNT_W'(CS_SETUP - 1)) state_next = SHIFT;
      SHIFT:   if (last_edge) state_next = HOLD;
      HOLD:    if (cnt == CNT_W'(CS_HOLD - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pin and status outputs are registered from the next state so they never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      edge_cnt     <= '0;
      first_idle   <= 1'b1;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      lmode_q      <= 2'd0;
      bus.sclk     <= 1'b0;
      bus.cs       <= 1'b1;
      bus.mosi     <= 4'b0000;
      bus.busy     <= 1'b0;
      bus.rx_valid <= 1'b0;
      bus.rx_data  <= '0;
    end else begin
      if (state == IDLE || tick || state_next != state) cnt <= '0;
      else                                              cnt <= cnt + 1'b1;

      if (state != SHIFT) edge_cnt <= '0;
      else if (tick)      edge_cnt <= edge_cnt + 1'b1;

      first_idle   <= (state_next == IDLE) && (state != IDLE);
      bus.cs       <= (state_next == IDLE);
      bus.busy     <= (state_next != IDLE);
      bus.rx_valid <= (state == HOLD) && (state_next == IDLE);
      if ((state == HOLD) && (state_next == IDLE)) bus.rx_data <= rx_sr;

      if (state == IDLE)       bus.sclk <= bus.cpol;
      else if (state != SHIFT) bus.sclk <= cpol_q;
      else if (tick)           bus.sclk <= ~bus.sclk;

      if (accept) begin
        cpol_q   <= bus.cpol;
        cpha_q   <= bus.cpha;
        lmode_q  <= lmode_in;
        bus.mosi <= bus.cpha ? 4'b0000 : beat_out(bus.tx_data, lmode_in);
      end else if (drive_beat) begin
        bus.mosi <= beat_out(tx_sr, lmode_q);
      end else if ((state_next == IDLE) && (state != IDLE)) begin
        bus.mosi <= 4'b0000;
      end
    end
  end

  // Shift registers carry data only; every bit is rewritten before it is used.
  always_ff @(posedge clk) begin
    if (accept)          tx_sr <= bus.cpha ? bus.tx_data : shift_out(bus.tx_data, lmode_in);
    else if (drive_beat) tx_sr <= shift_out(tx_sr, lmode_q);
    if (sample_beat)     rx_sr <= shift_in(rx_sr, bus.miso, lmode_q);
  end
endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- RTL SPI master that turns parallel words into serial transfers on the SPI pin bundle: sclk, cs, mosi0..3, miso0..3.
- Sits directly upstream of the SPI interface pins. Drives sclk/cs/mosi and samples miso, so the master/slave monitors and slave driver observe and respond to it.
- Supports single-, dual- and quad-lane transfers in all four CPOL/CPHA modes.
- Handshake: valid/ready word in, one-cycle rx_valid pulse out.

Parameters:
- DATA_WIDTH, 8, bits per transfer; must be a multiple of 4.
- CLK_DIV, 2, clk cycles per sclk half-period; must be ≥1.
- CS_SETUP, 1, clk cycles cs is low before the first sclk edge; must be ≥1.
- CS_HOLD, 1, clk cycles cs stays low after the last sclk edge; must be ≥1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- tx_data  in  DATA_WIDTH  word to transmit, MSB first.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  controller can accept a word.
- cpol  in  1  sclk idle level; sampled at accept.
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; sampled at accept.
- lanes  in  2  0 = single, 1 = dual, 2 = quad, 3 = treated as single; sampled at accept.
- rx_data  out  DATA_WIDTH  word received on miso.
- rx_valid  out  1  one-cycle pulse when rx_data is valid.
- busy  out  1  high in every state except IDLE.
- sclk  out  1  SPI clock.
- cs  out  1  active-low chip select.
- mosi  out  4  mosi[k] drives mosik.
- miso  in  4  miso[k] from misok.

Behaviour:
- Reset values: cs=1, sclk=0, mosi=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0, state=IDLE.
- Reset asserted mid-transfer aborts immediately. No rx_valid is produced for the aborted word.
- States and transitions:
  - IDLE: cs=1; sclk follows the cpol input (registered). tx_ready=0 on the IDLE entry cycle and 1 on every later IDLE cycle. Accept on clk edge when tx_valid&&tx_ready.
  - At accept: latch tx_data, cpol, cpha, L (lanes: 1/2/4). Set beats = DATA_WIDTH/L. Go to SETUP.
  - SETUP: cs=0. Lasts CS_SETUP cycles. If cpha=0, the first beat is driven on mosi on SETUP entry. Then go to SHIFT.
  - SHIFT: lasts 2*beats*CLK_DIV cycles. sclk register toggles every CLK_DIV cycles, giving 2*beats edges. The last edge returns sclk to cpol. Then go to HOLD.
  - HOLD: cs=0 for CS_HOLD cycles. Then go to IDLE, with cs=1 and rx_valid=1 for that one cycle.
- Edge roles:
  - cpha=0: sample miso on each leading edge; drive the next beat on each trailing edge except the last.
  - cpha=1: drive a beat on each leading edge; sample on each trailing edge.
  - "Sample" means capturing the miso pins at the same clk edge that toggles sclk.
- Lane mapping:
  - Each beat carries the next L bits of the shift register, MSB first. Lane L-1 carries the most significant bit of the group.
  - Unused mosi lanes drive 0; unused miso lanes are ignored.
  - Single lane uses mosi0/miso0 only.
- Received bits shift into rx_data in the same MSB-first order.
- Config inputs changing mid-transfer have no effect.
- Minimum cs-high gap between back-to-back words is 2 clk cycles.
- tx_ready never asserts while cs=0.

Test Plan:
- Mode 0, single lane (DATA_WIDTH=8, CLK_DIV=2, cpol=0, cpha=0), tx 0xA5, miso0 looped to mosi0:
  - cs low exactly 34 cycles (1+32+1); 16 sclk edges; sclk idles 0.
  - mosi0 sequence is 1,0,1,0,0,1,0,1.
  - rx_valid pulses once, with rx_data=0xA5.
- Mode 3, single lane (cpol=1, cpha=1), slave drives 0x3C on the trailing-edge-aligned schedule:
  - sclk idles 1 and leading edge is falling.
  - rx_data=0x3C; mosi changes only on leading edges.
- Quad lane, mode 0, tx 0xC6, miso[3:0] looped to mosi[3:0]:
  - 2 beats; mosi = 4'hC then 4'h6.
  - cs low 10 cycles; rx_data=0xC6.
- Dual lane, mode 1, tx 0x1B:
  - mosi[1:0] sequence is 00, 01, 10, 11.
  - mosi[3:2] stays 0; 4 beats.
- Back-to-back: tx_valid held high with 0x11 then 0x22:
  - cs high exactly 2 cycles between words.
  - Two rx_valid pulses; busy low only during the gap.
- Reset after 5 sclk edges of a transfer:
  - Next cycle cs=1, sclk=0, mosi=0, no rx_valid.
  - tx_ready=1 on the second cycle after reset release.
